rotary_focus_ctrl: RTL and testbench

- Shares the single front-panel rotary encoder between N_CLIENTS editable targets (e.g. node selector, register editor, clock-speed setting).
- Consumes the decoder's one-cycle cw/ccw step pulses plus a debounced push-button pulse.
- NAV state: steps move focus among enabled clients. EDIT state: steps are accumulated and delivered to the focused client as signed deltas over a valid/ready handshake.

---
 rtl/rotary_focus_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_rotary_focus_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rotary_focus_ctrl.sv
// Rotary encoder focus/edit arbiter: steps move focus among enabled clients in NAV,
// or accumulate into signed deltas in EDIT. Optional macro ROT_ACCEL_EN adds step acceleration.
module rotary_focus_ctrl #(
  parameter int N_CLIENTS      = 4,
  parameter int DELTA_W        = 8,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int ACCEL_WINDOW   = 2500000,
  localparam int IDX_W         = $clog2(N_CLIENTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step_cw,
  input  logic                 step_ccw,
  input  logic                 btn_press,
  input  logic [N_CLIENTS-1:0] client_en,
  output logic [IDX_W-1:0]     focus,
  output logic                 editing,
  output logic                 delta_valid,
  output logic [DELTA_W-1:0]   delta,
  input  logic                 delta_ready
);

  // state | meaning
  // NAV   | steps move focus among enabled clients
  // EDIT  | steps accumulate into deltas for the focused client
  // FLUSH | steps ignored, remaining accumulator/pending delta drained
  typedef enum logic [1:0] {NAV, EDIT, FLUSH} state_t;

  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);
  localparam logic signed [DELTA_W+1:0] SAT_P = (DELTA_W+2)'((1 << (DELTA_W - 1)) - 1);
  localparam logic signed [DELTA_W+1:0] SAT_N = -SAT_P;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           focus_q, focus_d;
  logic                       editing_q, editing_d;
  logic signed [DELTA_W-1:0]  acc_q, acc_d;
  logic [DELTA_W-1:0]         delta_q, delta_d;
  logic                       valid_q, valid_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;

  logic                       net_cw, net_ccw, net_step, counting, hs, abort;
  logic signed [DELTA_W+1:0]  step_mag, step_val, sum_raw;
  logic signed [DELTA_W-1:0]  sum_sat;

  function automatic logic [IDX_W-1:0] next_focus(input logic [IDX_W-1:0] cur,
                                                  input logic [N_CLIENTS-1:0] en,
                                                  input logic up);
    logic [IDX_W-1:0] res, cand;
    res = cur;
    // Descending scan so the nearest enabled candidate is the last one written.
    for (int k = N_CLIENTS - 1; k >= 1; k--) begin
      if (up) cand = IDX_W'((int'(cur) + k) % N_CLIENTS);
      else    cand = IDX_W'((int'(cur) + N_CLIENTS - k) % N_CLIENTS);
      if (en[cand]) res = cand;
    end
    return res;
  endfunction

  assign net_cw   = step_cw & ~step_ccw;
  assign net_ccw  = step_ccw & ~step_cw;
  assign net_step = net_cw | net_ccw;
  assign counting = (state_q == EDIT) && net_step;
  assign hs       = valid_q & delta_ready;
  assign abort    = (state_q != NAV) && !client_en[focus_q];

`ifdef ROT_ACCEL_EN
  localparam int AW_W = $clog2(ACCEL_WINDOW + 1);
  logic [AW_W-1:0] win_q, win_d;
  logic            last_cw_q, last_cw_d, have_prev_q, have_prev_d;

  always_comb begin
    win_d       = win_q;
    last_cw_d   = last_cw_q;
    have_prev_d = have_prev_q;
    step_mag    = (have_prev_q && (last_cw_q == net_cw) && (win_q != '0)) ? 'sd4 : 'sd1;
    if (state_q != EDIT || abort) begin
      win_d       = '0;
      last_cw_d   = 1'b0;
      have_prev_d = 1'b0;
    end else if (counting) begin
      win_d       = AW_W'(ACCEL_WINDOW);
      last_cw_d   = net_cw;
      have_prev_d = 1'b1;
    end else if (win_q != '0) begin
      win_d = win_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q       <= '0;
      last_cw_q   <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      last_cw_q   <= last_cw_d;
      have_prev_q <= have_prev_d;
    end
  end
`else
  assign step_mag = 'sd1;
`endif

  always_comb begin
    step_val = '0;
    if (counting) step_val = net_cw ? step_mag : -step_mag;
    sum_raw = $signed({{2{acc_q[DELTA_W-1]}}, acc_q}) + step_val;
    if (sum_raw > SAT_P)      sum_sat = SAT_P[DELTA_W-1:0];
    else if (sum_raw < SAT_N) sum_sat = SAT_N[DELTA_W-1:0];
    else                      sum_sat = sum_raw[DELTA_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    focus_d = focus_q;
    acc_d   = acc_q;
    delta_d = delta_q;
    valid_d = valid_q;
    tmo_d   = tmo_q;
    case (state_q)
      NAV: begin
        acc_d   = '0;
        valid_d = 1'b0;
        tmo_d   = '0;
        if (btn_press && client_en[focus_q]) begin
          state_d = EDIT;
          tmo_d   = TMO_LOAD;
        end else if (net_cw) begin
          focus_d = next_focus(focus_q, client_en, 1'b1);
        end else if (net_ccw) begin
          focus_d = next_focus(focus_q, client_en, 1'b0);
        end
      end
      EDIT, FLUSH: begin
        // Output register loads when empty or being consumed this cycle.
        if (!valid_q || hs) begin
          if (sum_sat != '0) begin
            delta_d = sum_sat;
            acc_d   = '0;
            valid_d = 1'b1;
          end else begin
            acc_d   = '0;
            valid_d = 1'b0;
          end
        end else begin
          acc_d = sum_sat;
        end
        if (state_q == EDIT) begin
          if (net_step || btn_press) tmo_d = TMO_LOAD;
          if (btn_press) begin
            state_d = FLUSH;
          end else if (!net_step && TIMEOUT_CYCLES != 0) begin
            if (tmo_q == '0) state_d = FLUSH;
            else             tmo_d   = tmo_q - 1'b1;
          end
        end else if (acc_q == '0 && !valid_q) begin
          state_d = NAV;
        end
      end
      default: state_d = NAV;
    endcase
    if (abort) begin
      state_d = NAV;
      acc_d   = '0;
      valid_d = 1'b0;
      tmo_d   = '0;
    end
    editing_d = (state_d != NAV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= NAV;
      focus_q   <= '0;
      editing_q <= 1'b0;
      acc_q     <= '0;
      delta_q   <= '0;
      valid_q   <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      focus_q   <= focus_d;
      editing_q <= editing_d;
      acc_q     <= acc_d;
      delta_q   <= delta_d;
      valid_q   <= valid_d;
      tmo_q     <= tmo_d;
    end
  end

  assign focus       = focus_q;
  assign editing     = editing_q;
  assign delta_valid = valid_q;
  assign delta       = delta_q;

endmodule

// File: tb/tb_rotary_focus_ctrl.sv
// Scoreboard bench for rotary_focus_ctrl: stimulus pushes expected deltas, a negedge
// monitor pops them on each handshake. Accel expectations follow ROT_ACCEL_EN.
module tb_rotary_focus_ctrl;
  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          step_cw, step_ccw, btn_press, delta_ready;
  logic [N-1:0]  client_en;
  logic [1:0]    focus;
  logic          editing, delta_valid;
  logic [DW-1:0] delta;

  int n_checks = 0;
  int n_fail   = 0;
  logic signed [DW-1:0] exp_q[$];

  rotary_focus_ctrl #(
    .N_CLIENTS(N), .DELTA_W(DW), .TIMEOUT_CYCLES(100), .ACCEL_WINDOW(20)
  ) dut (
    .clk(clk), .rst(rst), .step_cw(step_cw), .step_ccw(step_ccw), .btn_press(btn_press),
    .client_en(client_en), .focus(focus), .editing(editing), .delta_valid(delta_valid),
    .delta(delta), .delta_ready(delta_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic cw, input logic ccw);
    step_cw = cw; step_ccw = ccw;
    tick(1);
    step_cw = 1'b0; step_ccw = 1'b0;
  endtask

  task automatic press();
    btn_press = 1'b1;
    tick(1);
    btn_press = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (editing && n < budget) begin
      tick(1);
      n++;
    end
    check(name, int'(editing), 0);
  endtask

  // Monitor: every handshake consumes one expected delta.
  always @(negedge clk) begin
    if (!rst && delta_valid && delta_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_delta: got %0d, expected none", $signed(delta));
      end else begin
        check("delta", $signed(delta), exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; step_cw = 1'b0; step_ccw = 1'b0; btn_press = 1'b0;
    delta_ready = 1'b0; client_en = 4'b1011;
    tick(2);
    check("rst_focus", focus, 0);
    check("rst_editing", editing, 0);
    check("rst_valid", delta_valid, 0);
    check("rst_delta", delta, 0);
    rst = 1'b0;
    tick(1);

    // Focus wrap over enabled set {0,1,3}
    pulse(1, 0); check("wrap_cw1", focus, 1);
    pulse(1, 0); check("wrap_cw2", focus, 3);
    pulse(1, 0); check("wrap_cw3", focus, 0);
    pulse(0, 1); check("wrap_ccw", focus, 3);
    pulse(1, 1); check("nav_both", focus, 3);
    pulse(0, 1); check("to_client1", focus, 1);

    // Edit delivery
    press();
    check("edit_enter", editing, 1);
    delta_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'sd1);
      pulse(1, 0);
      tick(9);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(-8'sd1);
      pulse(0, 1);
      tick(9);
    end
    check("idle_valid", delta_valid, 0);

    // Backpressure and saturation
    delta_ready = 1'b0;
    exp_q.push_back(8'sd1);
    exp_q.push_back(8'sd127);
    for (int i = 0; i < 200; i++) begin
      pulse(1, 0);
      tick(1);
      if (i == 100) check("bp_hold_mid", $signed(delta), 1);
    end
    check("bp_hold_delta", $signed(delta), 1);
    check("bp_hold_valid", delta_valid, 1);
    delta_ready = 1'b1;
    tick(3);
    check("bp_drained", delta_valid, 0);
    check("bp_still_edit", editing, 1);

    // Simultaneous steps then flush
    pulse(1, 1);
    tick(3);
    check("both_valid", delta_valid, 0);
    delta_ready = 1'b0;
    exp_q.push_back(8'sd1);
    exp_q.push_back(8'sd2);
    for (int i = 0; i < 3; i++) pulse(1, 0);
    press();
    pulse(1, 0); pulse(0, 1); press();
    tick(2);
    check("flush_editing", editing, 1);
    check("flush_delta", $signed(delta), 1);
    delta_ready = 1'b1;
    wait_idle("flush_exit", 20);

    // Timeout
    check("tmo_focus", focus, 1);
    press();
    check("tmo_enter", editing, 1);
    n = 0;
    while (editing && n < 200) begin
      tick(1);
      n++;
    end
    check("tmo_cycles", n, 102);

    // Abort on client disable
    press();
    delta_ready = 1'b0;
    pulse(1, 0);
    check("abort_pending", delta_valid, 1);
    client_en = 4'b1001;
    tick(1);
    check("abort_valid", delta_valid, 0);
    check("abort_editing", editing, 0);
    check("abort_focus", focus, 1);
    delta_ready = 1'b1;
    tick(2);
    pulse(1, 0);
    check("abort_next_focus", focus, 3);
    client_en = 4'b1011;

    // Acceleration (plain +/-1 when the feature is built out)
    press();
    check("accel_enter", editing, 1);
    exp_q.push_back(8'sd1);
    pulse(1, 0);
    tick(4);
`ifdef ROT_ACCEL_EN
    exp_q.push_back(8'sd4);
`else
    exp_q.push_back(8'sd1);
`endif
    pulse(1, 0);
    tick(30);
    exp_q.push_back(8'sd1);
    pulse(1, 0);
    tick(4);
    exp_q.push_back(-8'sd1);
    pulse(0, 1);
    tick(5);
    press();
    wait_idle("accel_exit", 20);

    tick(10);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
